// File: rtl/led_mode_ctrl.sv
// ---------------------------------------------------------------------------
// led_mode_ctrl
//
// Drives the 4-LED board bank through one of four display modes (FLOW,
// BOUNCE, BLINK, OFF) at one of four step rates. Mode and speed advance on
// debounced single-cycle key pulses. A pause level freezes the step counter
// and the pattern.
//
// Optional build macro: LED_AUTO_CYCLE_EN
//   When it is defined, the mode advances automatically after AUTO_STEPS ticks
//   (FLOW -> BOUNCE -> BLINK -> FLOW; OFF is entered only by key). When it is
//   undefined, the AUTO_STEPS parameter and the auto counter do not exist.
//
// Parameters:
//   CNT_MAX    - base step divider; at speed 0, one step every CNT_MAX+1 cycles
//   AUTO_STEPS - ticks per mode before auto-advance (LED_AUTO_CYCLE_EN only)
//
// Ports:
//   clk        - system clock
//   rst_n      - asynchronous active-low reset
//   key_mode   - single-cycle pulse, advance display mode (wraps 3 -> 0)
//   key_speed  - single-cycle pulse, advance speed level (wraps 3 -> 0)
//   pause      - level, 1 freezes step counter and LED pattern
//   led[3:0]   - LED drive, active-low (0 = lit)
//   mode[1:0]  - current mode: 0 FLOW, 1 BOUNCE, 2 BLINK, 3 OFF
//   speed[1:0] - current speed level; step period is (CNT_MAX >> speed) + 1
//   step       - one-cycle pulse, aligned with each pattern advance
// ---------------------------------------------------------------------------
module led_mode_ctrl #(
    parameter logic [25:0] CNT_MAX    = 26'd24_999_999
`ifdef LED_AUTO_CYCLE_EN
   ,parameter logic [7:0]  AUTO_STEPS = 8'd16
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    input  logic       pause,
    output logic [3:0] led,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       step
);

    typedef enum logic [1:0] {
        MODE_FLOW   = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    // Active-low patterns: a single 0 marks the lit LED.
    localparam logic [3:0] LED_P0  = 4'b1110;
    localparam logic [3:0] LED_P1  = 4'b1101;
    localparam logic [3:0] LED_P2  = 4'b1011;
    localparam logic [3:0] LED_P3  = 4'b0111;
    localparam logic [3:0] LED_ALL = 4'b0000;
    localparam logic [3:0] LED_NONE = 4'b1111;

    function automatic logic [3:0] init_pattern(input mode_e m);
        case (m)
            MODE_FLOW, MODE_BOUNCE: init_pattern = LED_P0;
            MODE_BLINK:             init_pattern = LED_ALL;
            default:                init_pattern = LED_NONE;
        endcase
    endfunction

    mode_e       mode_q,  mode_d;
    logic [1:0]  speed_q, speed_d;
    logic [25:0] cnt_q,   cnt_d;
    logic [3:0]  led_q,   led_d;
    logic        dir_q,   dir_d;
    logic        step_q,  step_d;

    logic [25:0] limit;
    logic        cnt_done;
    logic        tick;
    logic        auto_adv;
    logic        mode_chg;
    logic [1:0]  mode_inc;

`ifdef LED_AUTO_CYCLE_EN
    localparam logic [7:0] AUTO_LAST = AUTO_STEPS - 8'd1;
    logic [7:0] auto_cnt_q, auto_cnt_d;
`endif

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        mode_d   = mode_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        led_d    = led_q;
        dir_d    = dir_q;
        step_d   = 1'b0;

        limit    = CNT_MAX >> speed_q;
        cnt_done = (cnt_q >= limit);
        // Any key on this edge suppresses the tick.
        tick     = !pause && cnt_done && !key_mode && !key_speed;
`ifdef LED_AUTO_CYCLE_EN
        auto_cnt_d = auto_cnt_q;
        auto_adv   = tick && (mode_q != MODE_OFF) && (auto_cnt_q == AUTO_LAST);
`else
        auto_adv   = 1'b0;
`endif
        mode_chg = key_mode || auto_adv;
        mode_inc = mode_q + 2'd1;

        if (key_speed) begin
            speed_d = speed_q + 2'd1;
        end

        if (mode_chg) begin
            // Auto-advance cycles through the three visible modes only.
            if (key_mode) begin
                mode_d = mode_e'(mode_inc);
            end else if (mode_q == MODE_BLINK) begin
                mode_d = MODE_FLOW;
            end else begin
                mode_d = mode_e'(mode_inc);
            end
            led_d = init_pattern(mode_d);
            dir_d = 1'b0;
        end else if (tick) begin
            step_d = 1'b1;
            case (mode_q)
                MODE_FLOW: begin
                    case (led_q)
                        LED_P0:  led_d = LED_P1;
                        LED_P1:  led_d = LED_P2;
                        LED_P2:  led_d = LED_P3;
                        default: led_d = LED_P0;
                    endcase
                end
                MODE_BOUNCE: begin
                    // The end positions have only one way out, so an end LED
                    // is never lit on two consecutive steps.
                    case (led_q)
                        LED_P0:  led_d = LED_P1;
                        LED_P1:  led_d = dir_q ? LED_P0 : LED_P2;
                        LED_P2:  led_d = dir_q ? LED_P1 : LED_P3;
                        LED_P3:  led_d = LED_P2;
                        default: led_d = LED_P0;
                    endcase
                    if (led_d == LED_P3) begin
                        dir_d = 1'b1;
                    end else if (led_d == LED_P0) begin
                        dir_d = 1'b0;
                    end
                end
                MODE_BLINK: begin
                    led_d = (led_q == LED_ALL) ? LED_NONE : LED_ALL;
                end
                default: begin
                    led_d = LED_NONE;
                end
            endcase
        end

        // A key or tick restarts the period; pause otherwise holds the count.
        if (mode_chg || key_speed || tick) begin
            cnt_d = '0;
        end else if (!pause) begin
            cnt_d = cnt_q + 26'd1;
        end

`ifdef LED_AUTO_CYCLE_EN
        if (mode_chg || (mode_q == MODE_OFF)) begin
            auto_cnt_d = '0;
        end else if (tick) begin
            auto_cnt_d = auto_cnt_q + 8'd1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q     <= MODE_FLOW;
            speed_q    <= 2'd0;
            cnt_q      <= '0;
            led_q      <= LED_P0;
            dir_q      <= 1'b0;
            step_q     <= 1'b0;
`ifdef LED_AUTO_CYCLE_EN
            auto_cnt_q <= '0;
`endif
        end else begin
            mode_q     <= mode_d;
            speed_q    <= speed_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
            dir_q      <= dir_d;
            step_q     <= step_d;
`ifdef LED_AUTO_CYCLE_EN
            auto_cnt_q <= auto_cnt_d;
`endif
        end
    end

    assign led   = led_q;
    assign mode  = mode_q;
    assign speed = speed_q;
    assign step  = step_q;

endmodule
